// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one SRAM-like memory port between the instruction-fetch requester and
// the data (load/store) requester. One request is accepted at a time: it is
// granted in IDLE, its fields are latched, driven to memory in REQ until the
// memory accepts the address, and the response is routed back to the owner in
// WAIT.
//
// Ports:
//   clk, rst                       clock (rising edge), async active-high reset
//   inst_req/inst_addr             fetch request in
//   inst_addr_ok/inst_data_ok      fetch accept / fetch data valid
//   inst_rdata                     fetch data (0 unless inst_data_ok)
//   data_req/wr/size/wstrb/addr/wdata   load/store request in
//   data_addr_ok/data_data_ok      load/store accept / completion
//   data_rdata                     load data (0 unless data_data_ok)
//   mem_req/wr/size/wstrb/addr/wdata    memory request out (latched fields)
//   mem_addr_ok/mem_data_ok/mem_rdata   memory handshakes and read data in
//   busy                           a transaction is in flight
//
// Build option:
//   MEM_ARB_RR_EN  when defined, simultaneous requests alternate between the
//                  two requesters (round robin) instead of data-over-inst.
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_req,
  input  logic [ADDR_W-1:0]     inst_addr,
  output logic                  inst_addr_ok,
  output logic                  inst_data_ok,
  output logic [DATA_W-1:0]     inst_rdata,
  input  logic                  data_req,
  input  logic                  data_wr,
  input  logic [1:0]            data_size,
  input  logic [DATA_W/8-1:0]   data_wstrb,
  input  logic [ADDR_W-1:0]     data_addr,
  input  logic [DATA_W-1:0]     data_wdata,
  output logic                  data_addr_ok,
  output logic                  data_data_ok,
  output logic [DATA_W-1:0]     data_rdata,
  output logic                  mem_req,
  output logic                  mem_wr,
  output logic [1:0]            mem_size,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_addr_ok,
  input  logic                  mem_data_ok,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy
);

  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

`ifdef MEM_ARB_RR_EN
  logic              last_owner_q, last_owner_d;
`endif

  logic in_idle;
  logic grant_data;
  logic grant_inst;
  logic resp_valid;

  assign in_idle = (state_q == ST_IDLE);

  // Arbitration decision; only acted upon while idle.
  always_comb begin
    grant_data = 1'b0;
    grant_inst = 1'b0;
`ifdef MEM_ARB_RR_EN
    // Tie goes to whoever was not granted last time.
    if (data_req && inst_req) begin
      grant_data = (last_owner_q == OWNER_INST);
    end else begin
      grant_data = data_req;
    end
`else
    grant_data = data_req;
`endif
    grant_inst = inst_req && !grant_data;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    wr_d    = wr_q;
    size_d  = size_q;
    wstrb_d = wstrb_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef MEM_ARB_RR_EN
    last_owner_d = last_owner_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (grant_data) begin
          state_d = ST_REQ;
          owner_d = OWNER_DATA;
          wr_d    = data_wr;
          size_d  = data_size;
          wstrb_d = data_wstrb;
          addr_d  = data_addr;
          wdata_d = data_wdata;
`ifdef MEM_ARB_RR_EN
          last_owner_d = OWNER_DATA;
`endif
        end else if (grant_inst) begin
          // Fetches are always full-word reads.
          state_d = ST_REQ;
          owner_d = OWNER_INST;
          wr_d    = 1'b0;
          size_d  = 2'b10;
          wstrb_d = '0;
          addr_d  = inst_addr;
          wdata_d = '0;
`ifdef MEM_ARB_RR_EN
          last_owner_d = OWNER_INST;
`endif
        end
      end
      ST_REQ: begin
        if (mem_addr_ok) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_data_ok) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWNER_INST;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      wstrb_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_owner_q <= OWNER_INST;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      wstrb_q <= wstrb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef MEM_ARB_RR_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  // addr_ok is combinational from the request inputs, so it is masked by rst
  // to keep every output quiet while reset is held.
  assign inst_addr_ok = !rst && in_idle && grant_inst;
  assign data_addr_ok = !rst && in_idle && grant_data;

  // A response only counts once the memory has taken the address; anything
  // arriving in IDLE or REQ is a stale leftover and is dropped.
  assign resp_valid   = (state_q == ST_WAIT) && mem_data_ok;
  assign inst_data_ok = resp_valid && (owner_q == OWNER_INST);
  assign data_data_ok = resp_valid && (owner_q == OWNER_DATA);
  assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
  assign data_rdata   = data_data_ok ? mem_rdata : '0;

  assign mem_req   = (state_q == ST_REQ);
  assign mem_wr    = wr_q;
  assign mem_size  = size_q;
  assign mem_wstrb = wstrb_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign busy = !in_idle;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Scoreboard bench for mem_arbiter. A driver applies one stimulus record per
// clock and feeds a transaction-level model that pushes expected grants and
// expected responses into queues; a monitor samples on the falling edge and
// pops/compares whenever the DUT presents addr_ok or data_ok. Memory read
// data is a fixed function of the address so the expected read value follows
// from the request alone.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_req;
  logic [AW-1:0] inst_addr;
  logic          inst_addr_ok, inst_data_ok;
  logic [DW-1:0] inst_rdata;
  logic          data_req, data_wr;
  logic [1:0]    data_size;
  logic [SW-1:0] data_wstrb;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic          data_addr_ok, data_data_ok;
  logic [DW-1:0] data_rdata;
  logic          mem_req, mem_wr;
  logic [1:0]    mem_size;
  logic [SW-1:0] mem_wstrb;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_addr_ok, mem_data_ok;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic [DW-1:0] rdata_noise;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents as seen by the arbiter: a fixed function of the address.
  function automatic logic [DW-1:0] mem_content(input logic [AW-1:0] a);
    return a ^ 32'h83C8_BFC0;
  endfunction

  assign mem_rdata = mem_data_ok ? mem_content(mem_addr) : rdata_noise;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  typedef struct {
    logic          rst;
    logic          ireq;
    logic [AW-1:0] iaddr;
    logic          dreq;
    logic          dwr;
    logic [1:0]    dsize;
    logic [SW-1:0] dwstrb;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dwdata;
    logic          maok;
    logic          mdok;
    logic [DW-1:0] noise;
  } stim_t;

  typedef struct {
    bit            is_data;
    logic          wr;
    logic [1:0]    size;
    logic [SW-1:0] wstrb;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  typedef struct {
    bit            is_data;
    logic [AW-1:0] addr;
    logic [DW-1:0] rdata;
  } resp_t;

  bit    grant_q[$];   // expected grant this cycle: 1 = data, 0 = inst
  resp_t resp_q[$];    // expected response this cycle

  // Transaction-level model state
  localparam int NONE = 0, ISSUED = 1, ACCEPTED = 2;
  int   stage = NONE;
  txn_t cur;
  bit   last_was_data = 1'b0;
  bit   exp_mem_req = 1'b0;
  bit   exp_busy = 1'b0;

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h, expected %08h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic stim_t quiet();
    stim_t s;
    s.rst = 1'b0; s.ireq = 1'b0; s.iaddr = '0; s.dreq = 1'b0; s.dwr = 1'b0;
    s.dsize = 2'b00; s.dwstrb = '0; s.daddr = '0; s.dwdata = '0;
    s.maok = 1'b0; s.mdok = 1'b0; s.noise = $urandom;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst    = ($urandom_range(0, 99) == 0);
    s.ireq   = ($urandom_range(0, 9) < 6);
    s.iaddr  = {$urandom, 2'b00} >> 2 << 2;
    s.dreq   = ($urandom_range(0, 9) < 6);
    s.dwr    = 1'($urandom);
    s.dsize  = 2'($urandom_range(0, 2));
    s.dwstrb = 4'($urandom);
    s.daddr  = $urandom;
    s.dwdata = $urandom;
    s.maok   = 1'($urandom);
    s.mdok   = 1'($urandom);
    s.noise  = $urandom;
    return s;
  endfunction

  // Advance the model by one clock using the inputs of this cycle.
  task automatic model_update(input stim_t s);
    bit pick_data;
    if (s.rst) begin
      grant_q.delete();
      resp_q.delete();
      stage = NONE;
      last_was_data = 1'b0;
      exp_mem_req = 1'b0;
      exp_busy = 1'b0;
      return;
    end
    exp_mem_req = (stage == ISSUED);
    exp_busy    = (stage != NONE);
    if (stage == NONE) begin
      if (s.dreq || s.ireq) begin
`ifdef MEM_ARB_RR_EN
        pick_data = s.dreq && (!s.ireq || !last_was_data);
`else
        pick_data = s.dreq;
`endif
        if (pick_data) begin
          cur.is_data = 1'b1; cur.wr = s.dwr; cur.size = s.dsize;
          cur.wstrb = s.dwstrb; cur.addr = s.daddr; cur.wdata = s.dwdata;
        end else begin
          cur.is_data = 1'b0; cur.wr = 1'b0; cur.size = 2'b10;
          cur.wstrb = '0; cur.addr = s.iaddr; cur.wdata = '0;
        end
        last_was_data = pick_data;
        grant_q.push_back(pick_data);
        stage = ISSUED;
      end
    end else if (stage == ISSUED) begin
      if (s.maok) stage = ACCEPTED;
    end else begin
      if (s.mdok) begin
        resp_q.push_back('{is_data: cur.is_data, addr: cur.addr, rdata: mem_content(cur.addr)});
        stage = NONE;
      end
    end
  endtask

  task automatic drive(input stim_t s);
    @(posedge clk);
    #1;
    rst = s.rst; inst_req = s.ireq; inst_addr = s.iaddr;
    data_req = s.dreq; data_wr = s.dwr; data_size = s.dsize; data_wstrb = s.dwstrb;
    data_addr = s.daddr; data_wdata = s.dwdata;
    mem_addr_ok = s.maok; mem_data_ok = s.mdok; rdata_noise = s.noise;
    #3;
    model_update(s);
  endtask

  task automatic monitor_cycle();
    bit    g;
    resp_t r;
    logic  any_out;
    if (rst) begin
      any_out = inst_addr_ok | inst_data_ok | (|inst_rdata) | data_addr_ok | data_data_ok |
                (|data_rdata) | mem_req | mem_wr | (|mem_size) | (|mem_wstrb) |
                (|mem_addr) | (|mem_wdata) | busy;
      chk("reset_outputs", 32'(any_out), 32'd0);
      return;
    end
    chk("mem_req", 32'(mem_req), 32'(exp_mem_req));
    chk("busy", 32'(busy), 32'(exp_busy));
    if (mem_req && exp_mem_req) begin
      chk("mem_addr", mem_addr, cur.addr);
      chk("mem_wr", 32'(mem_wr), 32'(cur.wr));
      chk("mem_size", 32'(mem_size), 32'(cur.size));
      chk("mem_wstrb", 32'(mem_wstrb), 32'(cur.wstrb));
      chk("mem_wdata", mem_wdata, cur.wdata);
    end
    if (inst_addr_ok || data_addr_ok) begin
      if (grant_q.size() == 0) begin
        chk("addr_ok_unexpected", 32'(inst_addr_ok | data_addr_ok), 32'd0);
      end else begin
        g = grant_q.pop_front();
        chk("grant_data", 32'(data_addr_ok), 32'(g));
        chk("grant_inst", 32'(inst_addr_ok), 32'(!g));
      end
    end else if (grant_q.size() != 0) begin
      g = grant_q.pop_front();
      chk("addr_ok_missing", 32'(inst_addr_ok | data_addr_ok), 32'd1);
    end
    if (inst_data_ok || data_data_ok) begin
      if (resp_q.size() == 0) begin
        chk("data_ok_unexpected", 32'(inst_data_ok | data_data_ok), 32'd0);
      end else begin
        r = resp_q.pop_front();
        chk("resp_data_owner", 32'(data_data_ok), 32'(r.is_data));
        chk("resp_inst_owner", 32'(inst_data_ok), 32'(!r.is_data));
        chk("resp_rdata", r.is_data ? data_rdata : inst_rdata, r.rdata);
        $display("txn %s addr=%08h rdata=%08h cycle=%0d",
                 r.is_data ? "data" : "inst", r.addr, r.is_data ? data_rdata : inst_rdata, cyc);
      end
    end else if (resp_q.size() != 0) begin
      r = resp_q.pop_front();
      chk("data_ok_missing", 32'(inst_data_ok | data_data_ok), 32'd1);
    end
    if (!inst_data_ok) chk("inst_rdata_zero", inst_rdata, 32'd0);
    if (!data_data_ok) chk("data_rdata_zero", data_rdata, 32'd0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      monitor_cycle();
    end
  end

  initial begin
    stim_t s;
    rst = 1'b1; inst_req = 1'b1; inst_addr = '0; data_req = 1'b1; data_wr = 1'b0;
    data_size = 2'b00; data_wstrb = '0; data_addr = '0; data_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; rdata_noise = '0;

    // Reset held with both requesters active: nothing may leak out.
    s = quiet(); s.rst = 1'b1; s.ireq = 1'b1; s.dreq = 1'b1;
    repeat (3) drive(s);
    drive(quiet());

    // Fetch only: accept, one-cycle address phase, one-cycle data phase.
    s = quiet(); s.ireq = 1'b1; s.iaddr = 32'hBFC0_0000; drive(s);
    s = quiet(); s.maok = 1'b1; drive(s);
    s = quiet(); s.mdok = 1'b1; drive(s);
    drive(quiet());

    // Byte store.
    s = quiet(); s.dreq = 1'b1; s.dwr = 1'b1; s.dsize = 2'b00; s.dwstrb = 4'b0100;
    s.daddr = 32'h8000_0012; s.dwdata = 32'hABAB_ABAB; drive(s);
    s = quiet(); s.maok = 1'b1; drive(s);
    s = quiet(); s.mdok = 1'b1; drive(s);
    drive(quiet());

    // Two simultaneous pairs; each requester drops its request once granted.
    for (int p = 0; p < 2; p++) begin
      s = quiet(); s.ireq = 1'b1; s.iaddr = 32'h0000_1000 + 32'(p * 16);
      s.dreq = 1'b1; s.daddr = 32'h0000_2000 + 32'(p * 16); s.dsize = 2'b10;
      drive(s);
      s.dreq = 1'b0; s.maok = 1'b1; drive(s);
      s.maok = 1'b0; s.mdok = 1'b1; drive(s);
      s.mdok = 1'b0; drive(s);
      s.ireq = 1'b0; s.maok = 1'b1; drive(s);
      s.maok = 1'b0; s.mdok = 1'b1; drive(s);
    end

    // Both held continuously with an always-ready memory.
    s = quiet(); s.ireq = 1'b1; s.iaddr = 32'h0000_3000; s.dreq = 1'b1;
    s.daddr = 32'h0000_4004; s.dsize = 2'b10; s.maok = 1'b1; s.mdok = 1'b1;
    repeat (12) drive(s);
    drive(quiet());

    // Memory backpressure: requesters churn while the address phase stalls.
    s = quiet(); s.dreq = 1'b1; s.daddr = 32'h8000_1000; s.dsize = 2'b10; drive(s);
    repeat (5) begin
      s = rand_stim(); s.rst = 1'b0; s.ireq = 1'b1; s.dreq = 1'b1;
      s.maok = 1'b0; s.mdok = 1'b1;
      drive(s);
    end
    s = quiet(); s.maok = 1'b1; drive(s);
    s = quiet(); s.mdok = 1'b1; drive(s);
    drive(quiet());

    // Reset while waiting for data, then a late response in IDLE.
    s = quiet(); s.ireq = 1'b1; s.iaddr = 32'h0000_5000; drive(s);
    s = quiet(); s.maok = 1'b1; drive(s);
    s = quiet(); s.rst = 1'b1; drive(s); drive(s);
    drive(quiet());
    s = quiet(); s.mdok = 1'b1; drive(s); drive(s);
    drive(quiet());

    // Random traffic.
    repeat (800) drive(rand_stim());

    // Drain.
    s = quiet(); s.maok = 1'b1; s.mdok = 1'b1;
    repeat (4) drive(s);
    drive(quiet());
    @(posedge clk);
    #6;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch requester and the data requester (the byte-lane/size formatter output of the MEM stage).
- Accepts one request at a time, latches it, drives it to memory, and routes the response back to its owner.
- Sits between the CPU core and the memory/bridge; the core stalls on missing addr_ok/data_ok.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- inst_req  in  1  fetch request
- inst_addr  in  ADDR_W  fetch address
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch data valid this cycle
- inst_rdata  out  DATA_W  fetch data
- data_req  in  1  load/store request
- data_wr  in  1  1=store, 0=load
- data_size  in  2  00 byte, 01 half, 10 word
- data_wstrb  in  DATA_W/8  byte write enables (store)
- data_addr  in  ADDR_W  load/store address
- data_wdata  in  DATA_W  lane-replicated store data
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  load data valid / store done this cycle
- data_rdata  out  DATA_W  load data (raw word)
- mem_req, mem_wr  out  1  memory request, write flag
- mem_size  out  2  memory size
- mem_wstrb  out  DATA_W/8  memory byte strobes
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_addr_ok, mem_data_ok  in  1  memory handshakes
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: "one clock; reset is asynchronous and active-high", ports clk and rst.
- FSM states: IDLE, REQ, WAIT. Reset puts the FSM in IDLE and clears all latched registers (owner, wr, size, wstrb, addr, wdata) to 0. All outputs read 0 during reset.
- IDLE: grant goes to data if data_req=1, else to inst if inst_req=1.
  - The granted requester's addr_ok is asserted combinationally in the same cycle.
  - The request fields are latched at the edge and the FSM goes to REQ.
  - An inst grant latches wr=0, size=10, wstrb=0, wdata=0.
- No grant in IDLE: stay in IDLE, both addr_ok low.
- REQ: mem_req=1 with the latched fields, held stable until mem_addr_ok=1, then WAIT. No requester addr_ok is asserted.
- WAIT: mem_req=0. When mem_data_ok=1:
  - the owner's data_ok=1 combinationally;
  - the owner's rdata = mem_rdata (also for stores, where the value is ignored);
  - the FSM returns to IDLE.
- Latency: accept in cycle N, mem_req from N+1, earliest data_ok in N+2 (mem_addr_ok in N+1, mem_data_ok in N+2).
- Next grant can occur in the cycle after data_ok.
- Non-owner handshakes stay 0 at all times. The rdata outputs are 0 when their data_ok is 0.
- mem_data_ok in IDLE or REQ is ignored (stale response after reset). mem_addr_ok outside REQ is ignored.
- A requester that drops req while not yet granted is not serviced.
- Inputs are not re-sampled after grant; requester changes during REQ/WAIT have no effect.
- Reset mid-REQ/WAIT aborts immediately to IDLE with mem_req=0. The owner receives no data_ok.

Optional Feature:
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - A 1-bit last_owner register (reset value: inst) is updated on every grant.
  - When both requesters are pending in IDLE, the grant goes to the one not equal to last_owner.
- Undefined: fixed data-over-inst priority as described above; no last_owner register.

Test Plan:
- Fetch only: inst_req=1, inst_addr=0xBFC00000; mem_addr_ok and mem_data_ok one cycle each, mem_rdata=0x3C08BFC0 -> inst_addr_ok in cycle 0, mem_req=1/mem_addr=0xBFC00000/mem_wr=0/mem_size=10 in cycle 1, inst_data_ok=1 with inst_rdata=0x3C08BFC0 in cycle 2.
- Byte store: data_wr=1, data_size=00, data_wstrb=0100, data_addr=0x80000012, data_wdata=0xABABABAB -> mem_wstrb=0100, mem_wdata=0xABABABAB, mem_wr=1; data_data_ok=1 when mem_data_ok=1; inst_* handshakes stay 0.
- Simultaneous requests from IDLE (default build): data granted first, inst granted in the cycle after data_data_ok. With MEM_ARB_RR_EN and a second simultaneous pair, the grant order alternates data, inst, data, inst.
- Memory backpressure: mem_addr_ok held 0 for 5 cycles -> mem_req and all mem_* fields stable for all 5 cycles; busy=1; no new addr_ok to either requester.
- Reset during WAIT: assert rst, then deassert; a late mem_data_ok=1 arrives in IDLE -> no data_ok on either requester, FSM remains IDLE, mem_req=0.
